// File: rtl/sobel_stream.sv
// Streaming 3x3 Sobel edge detector: two line buffers, 3x3 window, two-stage valid/ready pipeline.
// Optional binary output via `define SOBEL_THRESH_EN (m_data = mag >= thresh ? max : 0).

module sobel_kernel #(
  parameter int PIX_W = 8
) (
  input  logic [2:0][2:0][PIX_W-1:0] win,
  output logic [PIX_W+3:0]           mag
);
  localparam int SW = PIX_W + 3;

  function automatic logic signed [SW-1:0] ext(input logic [PIX_W-1:0] p);
    return $signed({3'b000, p});
  endfunction

  logic signed [SW-1:0] gx, gy;
  logic [SW-1:0] ax, ay;

  // win[r][c]: r=0 is the oldest (top) row, c=2 is the newest (right) column
  always_comb begin
    gx = (ext(win[0][2]) + ext(win[1][2]) + ext(win[1][2]) + ext(win[2][2]))
       - (ext(win[0][0]) + ext(win[1][0]) + ext(win[1][0]) + ext(win[2][0]));
    gy = (ext(win[2][0]) + ext(win[2][1]) + ext(win[2][1]) + ext(win[2][2]))
       - (ext(win[0][0]) + ext(win[0][1]) + ext(win[0][1]) + ext(win[0][2]));
    ax = gx[SW-1] ? -gx : gx;
    ay = gy[SW-1] ? -gy : gy;
    mag = {1'b0, ax} + {1'b0, ay};
  end
endmodule

module sobel_stream #(
  parameter int PIX_W = 8,
  parameter int IMG_W = 640,
  parameter int IMG_H = 480
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             s_valid,
  output logic             s_ready,
  input  logic [PIX_W-1:0] s_data,
  input  logic [PIX_W-1:0] thresh,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [PIX_W-1:0] m_data,
  output logic             m_sof,
  output logic             m_eol
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
  localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
  localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
  localparam logic [PIX_W-1:0] PMAX = {PIX_W{1'b1}};

  logic [CW-1:0] col;
  logic [RW-1:0] row;
  logic          en, xfer, interior;
  logic [1:0]    vld_pipe;  // [0]=window valid, [1]=output valid
  logic          sof1, eol1;

  logic [PIX_W-1:0] lb1 [IMG_W];  // row r-1
  logic [PIX_W-1:0] lb2 [IMG_W];  // row r-2
  logic [2:0][2:0][PIX_W-1:0] win;
  logic [PIX_W+3:0] mag;
  logic [PIX_W-1:0] res;

  assign en       = !m_valid || m_ready;
  assign s_ready  = en;
  assign xfer     = s_valid && en;
  assign interior = (row >= RW'(2)) && (col >= CW'(2));
  assign m_valid  = vld_pipe[1];

  // Line buffers and window carry no reset; nothing reads them before they are refilled
  always_ff @(posedge clk) begin
    if (xfer) begin
      lb1[col] <= s_data;
      lb2[col] <= lb1[col];
      for (int r = 0; r < 3; r++) begin
        win[r][0] <= win[r][1];
        win[r][1] <= win[r][2];
      end
      win[0][2] <= lb2[col];
      win[1][2] <= lb1[col];
      win[2][2] <= s_data;
    end
  end

  sobel_kernel #(.PIX_W(PIX_W)) u_kernel (.win(win), .mag(mag));

`ifdef SOBEL_THRESH_EN
  assign res = (mag >= {4'b0000, thresh}) ? PMAX : '0;
`else
  logic unused_thresh;
  assign unused_thresh = ^thresh;
  assign res = (mag > {4'b0000, PMAX}) ? PMAX : mag[PIX_W-1:0];
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      col      <= '0;
      row      <= '0;
      vld_pipe <= '0;
      sof1     <= 1'b0;
      eol1     <= 1'b0;
      m_data   <= '0;
      m_sof    <= 1'b0;
      m_eol    <= 1'b0;
    end else if (en) begin
      vld_pipe <= {vld_pipe[0], xfer && interior};
      sof1     <= xfer && (row == RW'(2)) && (col == CW'(2));
      eol1     <= xfer && interior && (col == COL_LAST);
      m_sof    <= sof1;
      m_eol    <= eol1;
      m_data   <= res;
      if (xfer) begin
        if (col == COL_LAST) begin
          col <= '0;
          row <= (row == ROW_LAST) ? '0 : row + 1'b1;
        end else begin
          col <= col + 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_sobel_stream.sv
// Directed bench for sobel_stream on an 8x6 image: table of column-step frames plus latency and reset sequences.
module tb_sobel_stream;
  localparam int W = 8, H = 6, NO = (W - 2) * (H - 2);

  logic clk = 0, rst = 1, s_valid = 0, s_ready, m_valid, m_ready = 1, m_sof, m_eol;
  logic [7:0] s_data = 0, thresh = 0, m_data;

  sobel_stream #(.PIX_W(8), .IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .thresh(thresh), .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data),
    .m_sof(m_sof), .m_eol(m_eol));

  always #5 clk = ~clk;

  int tests = 0, fails = 0, cyc = 0, t0 = -1, t1 = -1;
  bit rnd_rdy = 0, lat_arm = 0, stall_prev = 0;
  logic [7:0] hd; logic hs, he;
  logic [7:0] qd[$]; bit qs[$], qe[$];

  typedef struct {
    logic [7:0] left, right, thr;
    bit         rnd;
    logic [7:0] exp [6];
  } vec_t;
  vec_t v [];

  always @(posedge clk) cyc <= cyc + 1;

  initial forever begin
    @(posedge clk); #1;
    m_ready = rnd_rdy ? 1'($urandom_range(1, 0)) : 1'b1;
  end

  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // Output monitor: capture accepted beats, check hold during stalls
  always @(negedge clk) begin
    if (stall_prev) begin
      tests++;
      if (!(m_valid && m_data == hd && m_sof == hs && m_eol == he)) begin
        fails++;
        $display("FAIL stall_hold: got v=%0b d=%0d sof=%0b eol=%0b expected v=1 d=%0d sof=%0b eol=%0b",
                 m_valid, m_data, m_sof, m_eol, hd, hs, he);
      end
    end
    stall_prev = m_valid && !m_ready && !rst;
    hd = m_data; hs = m_sof; he = m_eol;
    if (m_valid && m_ready) begin
      qd.push_back(m_data); qs.push_back(m_sof); qe.push_back(m_eol);
    end
    if (lat_arm && m_valid) begin
      t1 = cyc; lat_arm = 0;
    end
  end

  task automatic send_pix(input logic [7:0] d, input bit rnd, input int idx);
    bit got = 0;
    if (rnd && $urandom_range(1, 0) == 1) begin
      s_valid = 0; @(posedge clk); #1;
    end
    s_data = d; s_valid = 1;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (s_ready) begin
        if (idx == 2 * W + 2) t0 = cyc;
        got = 1;
        break;
      end
    end
    if (!got) begin
      tests++; fails++;
      $display("FAIL s_ready_timeout: got 0 expected 1 at pixel %0d", idx);
    end
    @(posedge clk); #1;
    s_valid = 0;
  endtask

  task automatic send_frame(input logic [7:0] l, input logic [7:0] r, input bit rnd);
    for (int i = 0; i < W * H; i++) send_pix((i % W) < 4 ? l : r, rnd, i);
  endtask

  task automatic wait_outs(input int n);
    for (int k = 0; k < 400 && qd.size() < n; k++) @(posedge clk);
    rnd_rdy = 0;
    repeat (8) @(posedge clk);
    #1;
  endtask

  task automatic check_frames(input int id, input logic [7:0] exp [6], input int nf);
    int nsof = 0;
    chk($sformatf("count_%0d", id), qd.size(), NO * nf);
    for (int k = 0; k < qd.size() && k < NO * nf; k++) begin
      tests++;
      if (qd[k] != exp[k % 6] || qs[k] != (k % NO == 0) || qe[k] != (k % 6 == 5)) begin
        fails++;
        $display("FAIL out_%0d_%0d: got d=%0d sof=%0b eol=%0b expected d=%0d sof=%0b eol=%0b",
                 id, k, qd[k], qs[k], qe[k], exp[k % 6], k % NO == 0, k % 6 == 5);
      end
      if (qs[k]) nsof++;
    end
    chk($sformatf("sof_count_%0d", id), nsof, nf);
  endtask

  task automatic clear_q();
    qd.delete(); qs.delete(); qe.delete();
  endtask

  task automatic chk_reset_state(input string nm);
    chk({nm, "_m_valid"}, m_valid, 0);
    chk({nm, "_m_data"}, m_data, 0);
    chk({nm, "_m_sof"}, m_sof, 0);
    chk({nm, "_m_eol"}, m_eol, 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] step_row [6];
    logic [7:0] step_thr;
`ifdef SOBEL_THRESH_EN
    v = new[4];
    v[0] = '{8'd0,   8'd10,  8'd40, 1'b0, '{0, 0, 255, 255, 0, 0}};
    v[1] = '{8'd0,   8'd10,  8'd41, 1'b0, '{0, 0, 0, 0, 0, 0}};
    v[2] = '{8'd100, 8'd100, 8'd1,  1'b0, '{0, 0, 0, 0, 0, 0}};
    v[3] = '{8'd0,   8'd10,  8'd40, 1'b1, '{0, 0, 255, 255, 0, 0}};
    step_row = '{0, 0, 255, 255, 0, 0};
    step_thr = 8'd40;
`else
    v = new[8];
    v[0] = '{8'd100, 8'd100, 8'd0, 1'b0, '{0, 0, 0, 0, 0, 0}};
    v[1] = '{8'd0,   8'd10,  8'd0, 1'b0, '{0, 0, 40, 40, 0, 0}};
    v[2] = '{8'd0,   8'd200, 8'd0, 1'b0, '{0, 0, 255, 255, 0, 0}};
    v[3] = '{8'd0,   8'd63,  8'd0, 1'b0, '{0, 0, 252, 252, 0, 0}};
    v[4] = '{8'd0,   8'd64,  8'd0, 1'b0, '{0, 0, 255, 255, 0, 0}};
    v[5] = '{8'd10,  8'd0,   8'd0, 1'b0, '{0, 0, 40, 40, 0, 0}};
    v[6] = '{8'd0,   8'd10,  8'd0, 1'b1, '{0, 0, 40, 40, 0, 0}};
    v[7] = '{8'd0,   8'd200, 8'd0, 1'b1, '{0, 0, 255, 255, 0, 0}};
    step_row = '{0, 0, 40, 40, 0, 0};
    step_thr = 8'd0;
`endif

    // Reset state while rst is held
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk_reset_state("reset");
    @(posedge clk); #1;
    rst = 0;

    // Latency: pixel (2,2) accepted to first m_valid
    thresh = step_thr; clear_q(); lat_arm = 1; t0 = -1; t1 = -1;
    send_frame(8'd0, 8'd10, 1'b0);
    wait_outs(NO);
    chk("latency", t1 - t0, 2);
    check_frames(100, step_row, 1);

    foreach (v[i]) begin
      clear_q();
      thresh = v[i].thr;
      rnd_rdy = v[i].rnd;
      send_frame(v[i].left, v[i].right, v[i].rnd);
      wait_outs(NO);
      check_frames(i, v[i].exp, 1);
    end

    // Reset mid-frame, then two frames back-to-back
    clear_q(); thresh = step_thr; rnd_rdy = 0;
    for (int i = 0; i < 20; i++) send_pix((i % W) < 4 ? 8'd0 : 8'd10, 1'b0, i);
    rst = 1;
    @(negedge clk);
    @(negedge clk);
    chk_reset_state("midreset");
    @(posedge clk); #1;
    rst = 0;
    clear_q();
    send_frame(8'd0, 8'd10, 1'b0);
    send_frame(8'd0, 8'd10, 1'b0);
    wait_outs(2 * NO);
    check_frames(200, step_row, 2);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
